// File: rtl/iter_div_unit_if.sv
// Handshake and operand bundle between the execute-stage datapath and the iterative divider.
// Latency: none, plain wires.
// Backpressure: the divider holds its result while ready_o is high and ack_i is low.
interface iter_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic             signed_i;
   logic             annul_i;
   logic             ack_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             busy_o;
   logic             ready_o;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             div_by_zero_o;

   // Datapath side: issues divides and consumes results.
   modport master (
      output start_i, signed_i, annul_i, ack_i, dividend_i, divisor_i,
      input  busy_o, ready_o, quotient_o, remainder_o, div_by_zero_o
   );

   // Divider side.
   modport slave (
      input  start_i, signed_i, annul_i, ack_i, dividend_i, divisor_i,
      output busy_o, ready_o, quotient_o, remainder_o, div_by_zero_o
   );
endinterface

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider, optional signed mode, quotient -> LO, remainder -> HI.
// Latency: ready_o WIDTH cycles after an accepted start (1 cycle for a zero divisor).
// Backpressure: result held in DONE until ack_i; starts outside IDLE/DONE+ack are dropped.
module iter_div_unit #(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1,
   parameter int CNT_W     = $clog2(WIDTH+1)
) (
   input logic            clk,
   input logic            rst,
   iter_div_unit_if.slave divIf
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH-1);

   state_t           state, nextState;
   logic [WIDTH-1:0] remQ, dqQ, dvsQ, quoQ, rmdQ;
   logic [CNT_W-1:0] cntQ;
   logic             signQ, signRQ, dbzQ;

   logic             opSigned, dvdNeg, dvsNeg, dvsZero, accept, lastIter;
   logic [WIDTH-1:0] absDvd, absDvs;
   logic [WIDTH-1:0] itRem, itDq, itDvs, newRem, newDq, finalQ, finalR;
   logic [WIDTH:0]   itShift, itDiff;

   // Operand conditioning: magnitudes and signs of the incoming operands.
   assign opSigned = SIGNED_EN && divIf.signed_i;
   assign dvdNeg   = opSigned && divIf.dividend_i[WIDTH-1];
   assign dvsNeg   = opSigned && divIf.divisor_i[WIDTH-1];
   assign absDvd   = dvdNeg ? (~divIf.dividend_i + ONE) : divIf.dividend_i;
   assign absDvs   = dvsNeg ? (~divIf.divisor_i + ONE) : divIf.divisor_i;
   assign dvsZero  = (divIf.divisor_i == '0);

   // DONE with ack counts as idle, so a consumer can retire and reissue in one cycle.
   assign accept   = divIf.start_i && !divIf.annul_i &&
                     ((state == IDLE) || ((state == DONE) && divIf.ack_i));
   assign lastIter = (state == CALC) && (cntQ == CNT_END);

   // One shift/trial-subtract step; outside CALC it runs on the fresh operands so the
   // first iteration overlaps acceptance and the result lands WIDTH cycles after start.
   always_comb begin
      itRem = remQ;
      itDq  = dqQ;
      itDvs = dvsQ;
      if (state != CALC) begin
         itRem = '0;
         itDq  = absDvd;
         itDvs = absDvs;
      end
      itShift = {itRem, itDq[WIDTH-1]};
      itDiff  = itShift - {1'b0, itDvs};
      if (!itDiff[WIDTH]) begin
         newRem = itDiff[WIDTH-1:0];
         newDq  = {itDq[WIDTH-2:0], 1'b1};
      end else begin
         newRem = itShift[WIDTH-1:0];
         newDq  = {itDq[WIDTH-2:0], 1'b0};
      end
      finalQ = signQ  ? (~newDq + ONE)  : newDq;
      finalR = signRQ ? (~newRem + ONE) : newRem;
   end

   // Next-state logic; annul overrides everything.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (accept) nextState = dvsZero ? DONE : CALC;
         CALC: if (lastIter) nextState = DONE;
         DONE: begin
            if (accept)             nextState = dvsZero ? DONE : CALC;
            else if (divIf.ack_i)   nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      if (divIf.annul_i) nextState = IDLE;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // Datapath: operand latch, iteration registers and the held result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remQ   <= '0;
         dqQ    <= '0;
         dvsQ   <= '0;
         quoQ   <= '0;
         rmdQ   <= '0;
         cntQ   <= '0;
         signQ  <= 1'b0;
         signRQ <= 1'b0;
         dbzQ   <= 1'b0;
      end else if (accept) begin
         if (dvsZero) begin
            quoQ <= '1;
            rmdQ <= divIf.dividend_i;
            dbzQ <= 1'b1;
         end else begin
            remQ   <= newRem;
            dqQ    <= newDq;
            dvsQ   <= absDvs;
            signQ  <= dvdNeg ^ dvsNeg;
            signRQ <= dvdNeg;
            cntQ   <= CNT_ONE;
            dbzQ   <= 1'b0;
         end
      end else if (state == CALC) begin
         remQ <= newRem;
         dqQ  <= newDq;
         cntQ <= cntQ + CNT_ONE;
         if (lastIter) begin
            quoQ <= finalQ;
            rmdQ <= finalR;
         end
      end
   end

   assign divIf.busy_o        = (state == CALC);
   assign divIf.ready_o       = (state == DONE);
   assign divIf.div_by_zero_o = (state == DONE) && dbzQ;
   assign divIf.quotient_o    = quoQ;
   assign divIf.remainder_o   = rmdQ;
endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed corner cases plus randomized divides
// on a 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_iter_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   iter_div_unit_if #(.WIDTH(32)) bus32 ();
   iter_div_unit_if #(.WIDTH(8))  bus8 ();

   iter_div_unit #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (.clk(clk), .rst(rst), .divIf(bus32.slave));
   iter_div_unit #(.WIDTH(8),  .SIGNED_EN(1'b1)) dut8  (.clk(clk), .rst(rst), .divIf(bus8.slave));

   int errCnt = 0;
   int chkCnt = 0;
   bit use8   = 1'b0;

   logic        curReady, curBusy, curZ;
   logic [31:0] curQ, curR;

   always_comb begin
      curReady = bus32.ready_o;
      curBusy  = bus32.busy_o;
      curZ     = bus32.div_by_zero_o;
      curQ     = bus32.quotient_o;
      curR     = bus32.remainder_o;
      if (use8) begin
         curReady = bus8.ready_o;
         curBusy  = bus8.busy_o;
         curZ     = bus8.div_by_zero_o;
         curQ     = {24'h0, bus8.quotient_o};
         curR     = {24'h0, bus8.remainder_o};
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: truncating division on wide integers, results wrapped to w bits.
   function automatic void refDiv(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input bit sg, output logic [31:0] q, output logic [31:0] r,
                                  output bit z);
      longint      sa, sb, q64, r64;
      logic [31:0] mask, am, bm;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      am   = a & mask;
      bm   = b & mask;
      if (bm == 32'h0) begin
         q = mask;
         r = am;
         z = 1'b1;
         return;
      end
      sa = longint'({32'h0, am});
      sb = longint'({32'h0, bm});
      if (sg && am[w-1]) sa = sa - (longint'(1) << w);
      if (sg && bm[w-1]) sb = sb - (longint'(1) << w);
      q64 = sa / sb;
      r64 = sa % sb;
      q   = q64[31:0] & mask;
      r   = r64[31:0] & mask;
      z   = 1'b0;
   endfunction

   task automatic drive(input bit st, input logic [31:0] a, input logic [31:0] b, input bit sg);
      if (use8) begin
         bus8.start_i    = st;
         bus8.dividend_i = a[7:0];
         bus8.divisor_i  = b[7:0];
         bus8.signed_i   = sg;
      end else begin
         bus32.start_i    = st;
         bus32.dividend_i = a;
         bus32.divisor_i  = b;
         bus32.signed_i   = sg;
      end
   endtask

   task automatic setAck(input bit v);
      bus32.ack_i = v;
      bus8.ack_i  = v;
   endtask

   task automatic setAnnul(input bit v);
      bus32.annul_i = v;
      bus8.annul_i  = v;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Called one cycle after the accepting edge; waits for ready_o and checks the result.
   task automatic waitCheck(input string tag, input logic [31:0] expQ, input logic [31:0] expR,
                            input bit expZ, input int expLat);
      int cyc     = 1;
      int busyBad = 0;
      while (!curReady && cyc < 200) begin
         if (!curBusy) busyBad++;
         stepCycle();
         cyc++;
      end
      if (curBusy) busyBad++;
      checkVal({tag, " latency"}, 64'(cyc), 64'(expLat));
      checkVal({tag, " busy"}, 64'(busyBad), 64'd0);
      checkVal({tag, " quotient"}, {32'h0, curQ}, {32'h0, expQ});
      checkVal({tag, " remainder"}, {32'h0, curR}, {32'h0, expR});
      checkVal({tag, " dbz"}, {63'h0, curZ}, {63'h0, expZ});
   endtask

   // Issue one divide (ack held high) and check result plus ready drop afterwards.
   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input bit sg);
      logic [31:0] q, r;
      bit          z;
      int          w;
      w = use8 ? 8 : 32;
      refDiv(w, a, b, sg, q, r, z);
      drive(1'b1, a, b, sg);
      stepCycle();
      drive(1'b0, a, b, sg);
      waitCheck(tag, q, r, z, z ? 1 : w);
      stepCycle();
      checkVal({tag, " ready drop"}, {63'h0, curReady}, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q, r, a, b;
      bit          z, sg;
      int          seen;

      drive(1'b0, 32'h0, 32'h0, 1'b0);
      use8 = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      use8 = 1'b0;
      setAck(1'b1);
      setAnnul(1'b0);

      // Reset state
      #2;
      checkVal("reset ready", {63'h0, bus32.ready_o}, 64'd0);
      checkVal("reset busy", {63'h0, bus32.busy_o}, 64'd0);
      checkVal("reset quotient", {32'h0, bus32.quotient_o}, 64'd0);
      checkVal("reset remainder", {32'h0, bus32.remainder_o}, 64'd0);
      checkVal("reset dbz", {63'h0, bus32.div_by_zero_o}, 64'd0);
      #10 rst = 1'b1;
      stepCycle();

      // Directed 32-bit cases
      runOp("u 7/2", 32'd7, 32'd2, 1'b0);
      checkVal("u 7/2 quotient const", {32'h0, curQ}, 64'h3);
      runOp("s -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1);
      checkVal("s -7/2 quotient const", {32'h0, curQ}, 64'hFFFF_FFFD);
      checkVal("s -7/2 remainder const", {32'h0, curR}, 64'hFFFF_FFFF);
      runOp("s 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1);
      checkVal("s 7/-2 remainder const", {32'h0, curR}, 64'h1);
      runOp("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      checkVal("s ovf quotient const", {32'h0, curQ}, 64'h8000_0000);
      runOp("u maxneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      checkVal("u maxneg remainder const", {32'h0, curR}, 64'h8000_0000);
      runOp("zero 5/0", 32'd5, 32'd0, 1'b0);
      checkVal("zero quotient const", {32'h0, curQ}, 64'hFFFF_FFFF);

      // Annul in cycle 10, restart in cycle 12
      drive(1'b1, 32'd100, 32'd3, 1'b0);
      stepCycle();
      drive(1'b0, 32'd100, 32'd3, 1'b0);
      repeat (9) stepCycle();
      setAnnul(1'b1);
      stepCycle();
      setAnnul(1'b0);
      checkVal("annul busy", {63'h0, curBusy}, 64'd0);
      checkVal("annul ready", {63'h0, curReady}, 64'd0);
      stepCycle();
      checkVal("annul ready c12", {63'h0, curReady}, 64'd0);
      runOp("after annul", 32'd1234567, 32'd89, 1'b0);

      // Hold with ack low, ignored start, then ack+start back-to-back
      setAck(1'b0);
      refDiv(32, 32'd1000, 32'd7, 1'b0, q, r, z);
      drive(1'b1, 32'd1000, 32'd7, 1'b0);
      stepCycle();
      drive(1'b0, 32'd1000, 32'd7, 1'b0);
      waitCheck("hold", q, r, z, 32);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'd9, 32'd3, 1'b0);
         stepCycle();
         checkVal("hold ready", {63'h0, curReady}, 64'd1);
         checkVal("hold quotient", {32'h0, curQ}, {32'h0, q});
      end
      refDiv(32, 32'd50, 32'd5, 1'b0, q, r, z);
      drive(1'b1, 32'd50, 32'd5, 1'b0);
      setAck(1'b1);
      stepCycle();
      drive(1'b0, 32'd50, 32'd5, 1'b0);
      waitCheck("b2b", q, r, z, 32);
      stepCycle();

      // Reset in the middle of CALC
      drive(1'b1, 32'd77, 32'd5, 1'b0);
      stepCycle();
      drive(1'b0, 32'd77, 32'd5, 1'b0);
      repeat (5) stepCycle();
      #2 rst = 1'b0;
      #1;
      checkVal("midrst busy", {63'h0, bus32.busy_o}, 64'd0);
      checkVal("midrst ready", {63'h0, bus32.ready_o}, 64'd0);
      checkVal("midrst quotient", {32'h0, bus32.quotient_o}, 64'd0);
      checkVal("midrst remainder", {32'h0, bus32.remainder_o}, 64'd0);
      #3 rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         stepCycle();
         if (curReady) seen++;
      end
      checkVal("midrst no ready", 64'(seen), 64'd0);

      // 8-bit instance
      use8 = 1'b1;
      runOp("w8 200/7", 32'd200, 32'd7, 1'b0);
      checkVal("w8 quotient const", {32'h0, curQ}, 64'd28);
      checkVal("w8 remainder const", {32'h0, curR}, 64'd4);
      runOp("w8 s ovf", 32'h80, 32'hFF, 1'b1);
      for (int i = 0; i < 10; i++) begin
         a  = $urandom_range(0, 255);
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
         sg = 1'($urandom_range(0, 1));
         runOp("w8 rand", a, b, sg);
      end
      use8 = 1'b0;

      // Randomized 32-bit divides
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 15);
            2:       b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         sg = 1'($urandom_range(0, 1));
         runOp("rand32", a, b, sg);
      end

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end
endmodule
